gray_counter_system: RTL and testbench
======================================

GRAY_COUNTER_SYSTEM -- requirements
Module: gray_counter_system

Interface
REQ-001 Parameter N, default 4, width of the Gray count and of the LED bus; legal range N >= 2.
REQ-002 Parameter DIV, default 100000000, number of clk cycles per count step (1 step/s at 100 MHz); legal range DIV >= 1.
REQ-003 clk  input  1  single system clock, rising-edge active, nominal 100 MHz (10 ns period); the only clock in the block.
REQ-004 rst  input  1  reset, synchronous, active-high; sampled on the rising edge of clk.
REQ-005 leds  output  N  current Gray-coded count, driven directly from a register (no combinational path from any input).

Function
REQ-006 The block SHALL contain a prescaler counter of width ceil(log2(DIV)) (minimum 1 bit) that counts 0..DIV-1 on every clk edge and wraps to 0.
REQ-007 The prescaler SHALL assert an internal one-cycle tick when its value equals DIV-1; with DIV = 1 the tick SHALL be asserted every cycle.
REQ-008 The block SHALL hold an N-bit binary count that increments by 1 on each clk edge where tick is asserted and otherwise holds.
REQ-009 The binary count SHALL wrap from 2^N-1 to 0 with no stall, flag or extra cycle.
REQ-010 leds SHALL be registered and equal gray(b) = b XOR (b >> 1) of the binary count value b after the same edge, i.e. leds updates on the same edge that the binary count updates (zero additional latency relative to the count).
REQ-011 Successive leds values SHALL differ in exactly one bit, including the wrap step (N=4: 1000 -> 0000).
REQ-012 N=4 leds sequence from reset: 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then 0000 again.
REQ-013 The first leds change after reset release SHALL occur on the DIV-th rising edge of clk at which rst is low (prescaler 0 on the first such edge's input).
REQ-014 The block SHALL have no enable or load input; counting is free-running whenever rst is low.

Reset
REQ-015 When rst is high at a rising clk edge, the prescaler, binary count and leds SHALL all become 0 on that edge.
REQ-016 Reset SHALL take priority over tick: a tick coinciding with rst high SHALL be discarded.
REQ-017 Reset asserted mid-sequence, at any prescaler or count value, SHALL restart the sequence from REQ-013 after release.
REQ-018 The block SHALL not depend on power-up register values; behaviour is defined from the first edge with rst high.
REQ-019 rst SHALL not be used as a clock or as an asynchronous set/clear.

Verification
REQ-020 DIV=4, N=4, rst high 2 cycles then low -> leds = 0000 during reset, first change to 0001 on the 4th edge after release, then one step every 4 edges.
REQ-021 DIV=1, N=4, run 17 cycles after reset -> leds follows the full REQ-012 sequence, wraps 1000 -> 0000 on the 16th edge, 0001 on the 17th.
REQ-022 DIV=3, any N, run >= 2*2^N steps -> a checker confirms exactly one bit changes per step and leds equals b XOR (b>>1) of a reference binary counter.
REQ-023 DIV=4, N=4, assert rst for 1 cycle while leds = 0110 and prescaler = 2 -> leds = 0000 on that edge; next change to 0001 exactly 4 edges after release.
REQ-024 DIV=5, hold rst high while the prescaler would reach DIV-1 -> no step occurs; leds stays 0000 for the whole reset.
REQ-025 Default parameters, 100 MHz clock, 0.1 s simulation after reset release -> leds remains 0000 (no tick before 10^8 cycles).

Source files
------------

// File: rtl/gray_counter_system.sv
// -----------------------------------------------------------------------------
// gray_counter_system
//
// Purpose:
//   Free-running N-bit Gray-code counter for driving a LED bank. A prescaler
//   divides clk down to one count step every DIV cycles. The binary count
//   advances on each prescaler tick, and the Gray-coded value is registered
//   directly onto the LED bus.
//
// Parameters:
//   N    - width of the Gray count and LED bus (N >= 2)
//   DIV  - clk cycles per count step (DIV >= 1; DIV = 1 steps every cycle)
//
// Ports:
//   clk   in   1  system clock, rising-edge active
//   rst   in   1  synchronous active-high reset
//   leds  out  N  registered Gray-coded count
// -----------------------------------------------------------------------------
module gray_counter_system #(
  parameter int N   = 4,
  parameter int DIV = 100000000
) (
  input  logic         clk,
  input  logic         rst,
  output logic [N-1:0] leds
);

  // Prescaler width is ceil(log2(DIV)); $clog2(1) is 0, so keep at least one
  // bit so the register always exists.
  localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic [PW-1:0] r_presc;
  logic [N-1:0]  r_bin;
  logic [N-1:0]  r_leds;

  logic          w_tick;
  logic [N-1:0]  w_bin_next;
  logic [N-1:0]  w_gray_next;

  // With DIV = 1 the prescaler sits at 0 == PRESC_LAST, so tick is constant.
  assign w_tick      = (r_presc == PRESC_LAST);

  // Natural N-bit overflow gives the 2^N-1 -> 0 wrap with no extra cycle.
  assign w_bin_next  = r_bin + N'(1);

  // Gray is computed from the post-increment value so the LED register moves
  // on the same edge as the binary count.
  assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_bin   <= '0;
      r_leds  <= '0;
    end else begin
      if (w_tick) begin
        r_presc <= '0;
        r_bin   <= w_bin_next;
        r_leds  <= w_gray_next;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  assign leds = r_leds;

endmodule

// File: tb/tb_gray_counter_system.sv
module tb_gray_counter_system;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;
  logic rst_d = 1'b1;
  logic rst_e = 1'b1;

  logic [3:0] leds_a;
  logic [3:0] leds_b;
  logic [2:0] leds_c;
  logic [3:0] leds_d;
  logic [3:0] leds_e;

  gray_counter_system #(.N(4), .DIV(4)) u_div4 (.clk(clk), .rst(rst_a), .leds(leds_a));
  gray_counter_system #(.N(4), .DIV(1)) u_div1 (.clk(clk), .rst(rst_b), .leds(leds_b));
  gray_counter_system #(.N(3), .DIV(3)) u_div3 (.clk(clk), .rst(rst_c), .leds(leds_c));
  gray_counter_system #(.N(4), .DIV(5)) u_div5 (.clk(clk), .rst(rst_d), .leds(leds_d));
  gray_counter_system                   u_dflt (.clk(clk), .rst(rst_e), .leds(leds_e));

  int n_chk  = 0;
  int n_pass = 0;

  // Hand-written N=4 Gray sequence from reset.
  logic [3:0] seq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                           4'b0110, 4'b0111, 4'b0101, 4'b0100,
                           4'b1100, 4'b1101, 4'b1111, 4'b1110,
                           4'b1010, 4'b1011, 4'b1001, 4'b1000};

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t",
                  tag, obs, obs, exp, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] prev4;
    logic [2:0] prev3;
    int         mp;
    int         mb;
    bit         tk;

    // Common reset, two edges.
    step();
    step();
    chk("rst_a", leds_a, 0);
    chk("rst_b", leds_b, 0);
    chk("rst_c", leds_c, 0);
    chk("rst_d", leds_d, 0);
    chk("rst_e", leds_e, 0);
    rst_e = 1'b0;

    // DIV=4: first change on 4th edge after release, then every 4 edges.
    rst_a = 1'b0;
    for (int e = 1; e <= 18; e++) begin
      step();
      chk($sformatf("a_run%0d", e), leds_a, seq[e / 4]);
    end
    // Now leds = 0110 and prescaler = 2; one-cycle reset mid-sequence.
    rst_a = 1'b1;
    step();
    chk("a_midrst", leds_a, 0);
    rst_a = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk($sformatf("a_restart%0d", e), leds_a, (e >= 4) ? 1 : 0);
    end

    // DIV=1: full sequence with wrap on the 16th edge.
    rst_b = 1'b0;
    prev4 = 4'b0000;
    for (int k = 1; k <= 17; k++) begin
      step();
      chk($sformatf("b_seq%0d", k), leds_b, seq[k % 16]);
      chk($sformatf("b_1bit%0d", k), $countones(prev4 ^ leds_b), 1);
      prev4 = leds_b;
    end

    // DIV=3, N=3: reference model over more than two full wraps.
    rst_c = 1'b0;
    mp = 0;
    mb = 0;
    prev3 = 3'b000;
    for (int e = 1; e <= 54; e++) begin
      step();
      tk = (mp == 2);
      mp = tk ? 0 : mp + 1;
      if (tk) mb = (mb + 1) % 8;
      chk($sformatf("c_gray%0d", e), leds_c, mb ^ (mb >> 1));
      if (tk) chk($sformatf("c_1bit%0d", e), $countones(prev3 ^ leds_c), 1);
      prev3 = leds_c;
    end

    // DIV=5: reset held long past where the prescaler would have ticked.
    for (int e = 1; e <= 8; e++) begin
      step();
      chk($sformatf("d_hold%0d", e), leds_d, 0);
    end
    rst_d = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      chk($sformatf("d_first%0d", e), leds_d, (e >= 5) ? 1 : 0);
    end

    // Default DIV: no step within the simulated window.
    for (int k = 0; k < 20; k++) begin
      repeat (100) step();
      chk($sformatf("e_idle%0d", k), leds_e, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
